fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined RV32I core: owns the program counter, drives the byte address into the asynchronous instruction ROM, and registers the returned word into the IF/ID pipeline register for decode. Handles pipeline stall from hazard logic and PC redirect from branch/jump resolution, inserting a NOP bubble on redirect.

## Interface
- `ADDRESS_WIDTH`, 32: PC width, equal to the ROM address width.
- `RESET_VECTOR`, 32'h0000_0000: PC value after reset.
- `ROM_SPAN`, 12: number of significant ROM address bits, used only for `pc_oob_o`.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `stall_i`  in  1  hazard unit: hold PC and IF/ID.
- `redirect_i`  in  1  branch taken / jump resolved this cycle.
- `target_i`  in  ADDRESS_WIDTH  redirect address.
- `instr_i`  in  32  word from ROM for `pc_f_o` (same-cycle, combinational).
- `pc_f_o`  out  ADDRESS_WIDTH  current fetch PC, to ROM `PC` input.
- `pc_oob_o`  out  1  `pc_f_o` beyond ROM span (any bit ≥ ROM_SPAN set), or last word straddles end.
- `instr_d_o`  out  32  IF/ID instruction.
- `pc_d_o`  out  ADDRESS_WIDTH  IF/ID PC of that instruction.
- `pc_plus4_d_o`  out  ADDRESS_WIDTH  IF/ID PC+4 (for JAL/JALR link).
- `valid_d_o`  out  1  IF/ID holds a real instruction (0 = bubble).

## Operation
- PC register `pc_f`; next-PC priority: reset > redirect > stall > sequential.
  - reset: `RESET_VECTOR`.
  - redirect: `{target_i[ADDRESS_WIDTH-1:2], 2'b00}` (low bits forced zero; byte-addressed words, 4-byte stride).
  - stall (no redirect): hold.
  - else: `pc_f + 4`, modulo 2^ADDRESS_WIDTH (wraps FFFF_FFFC → 0000_0000, no flag).
- IF/ID register, same priority:
  - reset or redirect: `instr_d = NOP (32'h0000_0013)`, `pc_d = 0`, `pc_plus4_d = 0`, `valid_d = 0`.
  - stall: hold all four.
  - else: capture `instr_i`, `pc_f`, `pc_f + 4`, `valid_d = 1`.
- Redirect during stall: redirect wins for both registers (the stalled younger instruction is wrong-path).
- `pc_oob_o` combinational from `pc_f`: 1 if `pc_f[ADDRESS_WIDTH-1:ROM_SPAN] != 0` or `pc_f[ROM_SPAN-1:0] > 2^ROM_SPAN-4`. Informational only; fetch continues.
- No internal FSM beyond the two register sets; stage is always "running" after reset.

## Timing
- Reset values: `pc_f_o = RESET_VECTOR`, `instr_d_o = 32'h0000_0013`, `pc_d_o = 0`, `pc_plus4_d_o = 0`, `valid_d_o = 0`.
- Fetch latency: instruction at `pc_f` appears on `instr_d_o` one edge after `pc_f` is presented (ROM is zero-latency).
- First real instruction: cycle after reset release, `valid_d_o = 1`, `pc_d_o = RESET_VECTOR`.
- Redirect latency: `redirect_i` high at edge N → `pc_f_o = target` after N, bubble in IF/ID after N, target instruction in IF/ID after N+1.
- `stall_i`, `redirect_i`, `target_i` sampled only at rising edge; no combinational path from them to any output.
- Reset asserted mid-stream: all state returns to reset values at the next edge regardless of stall/redirect.

## Structure
- Shared package `riscv_pkg`: `XLEN = 32`, `NOP_INSTR = 32'h0000_0013`, `PC_STEP = 4`.
- One sub-module, `if_id_reg`: the stall/flush-capable IF/ID register (instr, pc, pc_plus4, valid); the PC register and next-PC mux stay in `fetch_stage`.
- ROM is instantiated by the top level, not inside this block.

## Test plan
- Reset then 4 free-running cycles, ROM model returns `0xAAAA_0000 | pc`: `pc_f_o` = 0,4,8,C; `pc_d_o` trails by one cycle; `valid_d_o` 0 then 1; `pc_plus4_d_o = pc_d_o + 4`.
- `stall_i` high 3 cycles at `pc_f = 8`: `pc_f_o` stays 8, IF/ID holds PC 4 unchanged; resumes 8→C on release, no instruction lost or duplicated.
- `redirect_i` with `target_i = 0x0000_0102` at `pc_f = 0x10`: next `pc_f_o = 0x100`, IF/ID = NOP/valid 0, following cycle `pc_d_o = 0x100`, valid 1.
- Redirect and stall same edge, target 0x40: `pc_f_o = 0x40`, IF/ID bubble (stall ignored).
- `RESET_VECTOR = 32'hFFFF_FFF8`: PC sequence FFF8, FFFC, 0000_0000; `pc_oob_o` = 1,1,0.
- `rst_n` low for one edge mid-stall with pending redirect: all outputs equal reset values next cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I core constants used by the fetch stage and its IF/ID register.
//   XLEN      : architectural word width
//   NOP_INSTR : canonical NOP (addi x0, x0, 0), used as the pipeline bubble
//   PC_STEP   : byte distance between sequential instructions
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam int PC_STEP = 4;

  typedef logic [XLEN-1:0] word_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's control, ROM and IF/ID signals.
//   slave  : the fetch stage side (takes stall/redirect/ROM word, drives PC and IF/ID)
//   master : the surrounding core side (hazard unit, branch unit, ROM, decode)
interface fetch_stage_if
  import riscv_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32
);
  logic                     stall_i;
  logic                     redirect_i;
  logic [ADDRESS_WIDTH-1:0] target_i;
  word_t                    instr_i;
  logic [ADDRESS_WIDTH-1:0] pc_f_o;
  logic                     pc_oob_o;
  word_t                    instr_d_o;
  logic [ADDRESS_WIDTH-1:0] pc_d_o;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_d_o;
  logic                     valid_d_o;

  modport slave (
    input  stall_i, redirect_i, target_i, instr_i,
    output pc_f_o, pc_oob_o, instr_d_o, pc_d_o, pc_plus4_d_o, valid_d_o
  );

  modport master (
    output stall_i, redirect_i, target_i, instr_i,
    input  pc_f_o, pc_oob_o, instr_d_o, pc_d_o, pc_plus4_d_o, valid_d_o
  );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with stall (hold) and flush (bubble) control.
//   clk, rst_n  : clock, synchronous active-low reset
//   stall_i     : hold current contents
//   flush_i     : load a bubble; wins over stall
//   instr_i, pc_i, pc_plus4_i : word being fetched this cycle
//   instr_o, pc_o, pc_plus4_o, valid_o : registered IF/ID contents
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_i,
  input  logic                     flush_i,
  input  word_t                    instr_i,
  input  logic [ADDRESS_WIDTH-1:0] pc_i,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_i,
  output word_t                    instr_o,
  output logic [ADDRESS_WIDTH-1:0] pc_o,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_o,
  output logic                     valid_o
);
  word_t                    instr_q, instr_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
  logic                     valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (flush_i) begin
      // A redirect makes whatever is here wrong-path, even if stalled.
      instr_d    = NOP_INSTR;
      pc_d       = '0;
      pc_plus4_d = '0;
      valid_d    = 1'b0;
    end else if (!stall_i) begin
      instr_d    = instr_i;
      pc_d       = pc_i;
      pc_plus4_d = pc_plus4_i;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, addresses the external
// zero-latency ROM and registers the returned word into IF/ID.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : fetch_stage_if.slave
//                in : stall_i, redirect_i, target_i, instr_i (ROM word for pc_f_o)
//                out: pc_f_o, pc_oob_o, instr_d_o, pc_d_o, pc_plus4_d_o, valid_d_o
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                     ROM_SPAN      = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.slave  bus
);
  localparam logic [ADDRESS_WIDTH-1:0] STEP      = ADDRESS_WIDTH'(PC_STEP);
  localparam logic [ADDRESS_WIDTH-1:0] WORD_MASK = ~ADDRESS_WIDTH'(3);
  localparam logic [ADDRESS_WIDTH-1:0] SPAN_MASK =
    (ADDRESS_WIDTH'(1) << ROM_SPAN) - ADDRESS_WIDTH'(1);
  // Byte address of the last whole word inside the ROM span.
  localparam logic [ADDRESS_WIDTH-1:0] LAST_WORD = SPAN_MASK - ADDRESS_WIDTH'(3);

  logic [ADDRESS_WIDTH-1:0] pc_f_q, pc_f_d;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_f;

  assign pc_plus4_f = pc_f_q + STEP;  // wraps modulo 2^ADDRESS_WIDTH

  always_comb begin
    pc_f_d = pc_plus4_f;
    if (bus.redirect_i)   pc_f_d = bus.target_i & WORD_MASK;
    else if (bus.stall_i) pc_f_d = pc_f_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pc_f_q <= RESET_VECTOR;
    else        pc_f_q <= pc_f_d;
  end

  assign bus.pc_f_o   = pc_f_q;
  assign bus.pc_oob_o = (|(pc_f_q & ~SPAN_MASK)) || ((pc_f_q & SPAN_MASK) > LAST_WORD);

  if_id_reg #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall_i    (bus.stall_i),
    .flush_i    (bus.redirect_i),
    .instr_i    (bus.instr_i),
    .pc_i       (pc_f_q),
    .pc_plus4_i (pc_plus4_f),
    .instr_o    (bus.instr_d_o),
    .pc_o       (bus.pc_d_o),
    .pc_plus4_o (bus.pc_plus4_d_o),
    .valid_o    (bus.valid_d_o)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// phase, compared against a cycle-level behavioural model of the fetch stream.
module tb_fetch_stage;
  import riscv_pkg::*;

  logic clk;
  logic rst_n;

  fetch_stage_if #(.ADDRESS_WIDTH(32)) fi ();
  fetch_stage_if #(.ADDRESS_WIDTH(32)) fw ();

  fetch_stage #(.ADDRESS_WIDTH(32), .RESET_VECTOR(32'h0000_0000), .ROM_SPAN(12)) dut (
    .clk(clk), .rst_n(rst_n), .bus(fi)
  );
  fetch_stage #(.ADDRESS_WIDTH(32), .RESET_VECTOR(32'hFFFF_FFF8), .ROM_SPAN(12)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .bus(fw)
  );

  function automatic logic [31:0] rom(input logic [31:0] pc);
    return 32'hAAAA_0000 | pc;
  endfunction

  assign fi.instr_i    = rom(fi.pc_f_o);
  assign fw.instr_i    = rom(fw.pc_f_o);
  assign fw.stall_i    = 1'b0;
  assign fw.redirect_i = 1'b0;
  assign fw.target_i   = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: the PC being fetched plus the instruction slot handed to decode.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        v;
  } slot_t;

  logic [31:0] m_pc;
  slot_t       m_d;

  function automatic slot_t bubble();
    slot_t s;
    s.instr = NOP_INSTR; s.pc = 0; s.pc4 = 0; s.v = 1'b0;
    return s;
  endfunction

  // Any part of the 4-byte word lies beyond the 4 KiB ROM.
  function automatic logic oob(input logic [31:0] pc);
    return pc > 32'd4092;
  endfunction

  function automatic void model_step(input bit rst, input bit st, input bit rd,
                                     input logic [31:0] tgt);
    if (rst) begin
      m_pc = 32'h0; m_d = bubble();
    end else if (rd) begin
      m_pc = {tgt[31:2], 2'b00}; m_d = bubble();
    end else if (!st) begin
      m_d.instr = rom(m_pc); m_d.pc = m_pc; m_d.pc4 = m_pc + 32'd4; m_d.v = 1'b1;
      m_pc = m_pc + 32'd4;
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".pc_f"},  fi.pc_f_o,       m_pc);
    chk({tag, ".oob"},   32'(fi.pc_oob_o), 32'(oob(m_pc)));
    chk({tag, ".instr"}, fi.instr_d_o,    m_d.instr);
    chk({tag, ".pc_d"},  fi.pc_d_o,       m_d.pc);
    chk({tag, ".pc4_d"}, fi.pc_plus4_d_o, m_d.pc4);
    chk({tag, ".vld"},   32'(fi.valid_d_o), 32'(m_d.v));
  endtask

  // Drive inputs on the falling edge, confirm they do not leak to outputs
  // before the clock, then advance one edge and compare against the model.
  task automatic cycle(input string tag, input bit rn, input bit st, input bit rd,
                       input logic [31:0] tgt);
    @(negedge clk);
    rst_n = rn; fi.stall_i = st; fi.redirect_i = rd; fi.target_i = tgt;
    #1;
    chk({tag, ".nocomb_pc"},  fi.pc_f_o, m_pc);
    chk({tag, ".nocomb_vld"}, 32'(fi.valid_d_o), 32'(m_d.v));
    model_step(!rn, st, rd, tgt);
    @(posedge clk); #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; fi.stall_i = 1'b0; fi.redirect_i = 1'b0; fi.target_i = '0;
    m_pc = 0; m_d = bubble();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.pc_f",  fi.pc_f_o, 32'h0);
    chk("rst.instr", fi.instr_d_o, 32'h0000_0013);
    chk("rst.pc_d",  fi.pc_d_o, 32'h0);
    chk("rst.pc4_d", fi.pc_plus4_d_o, 32'h0);
    chk("rst.vld",   32'(fi.valid_d_o), 32'h0);
    chk("wrap.pc0",  fw.pc_f_o, 32'hFFFF_FFF8);
    chk("wrap.oob0", 32'(fw.pc_oob_o), 32'h1);

    // Free-running fetch from the reset vector.
    cycle("run1", 1, 0, 0, 0);
    chk("run1.pc_d_lit", fi.pc_d_o, 32'h0);
    chk("run1.instr_lit", fi.instr_d_o, 32'hAAAA_0000);
    chk("wrap.pc1",  fw.pc_f_o, 32'hFFFF_FFFC);
    chk("wrap.oob1", 32'(fw.pc_oob_o), 32'h1);
    cycle("run2", 1, 0, 0, 0);
    chk("run2.pc_f_lit", fi.pc_f_o, 32'h8);
    chk("wrap.pc2",  fw.pc_f_o, 32'h0);
    chk("wrap.oob2", 32'(fw.pc_oob_o), 32'h0);
    chk("wrap.pc_d", fw.pc_d_o, 32'hFFFF_FFFC);
    chk("wrap.pc4",  fw.pc_plus4_d_o, 32'h0);

    // Stall for three edges at pc_f = 8, then release.
    for (int i = 0; i < 3; i++) cycle("stall", 1, 1, 0, 0);
    chk("stall.pc_f_lit", fi.pc_f_o, 32'h8);
    chk("stall.pc_d_lit", fi.pc_d_o, 32'h4);
    cycle("unstall", 1, 0, 0, 0);
    chk("unstall.pc_d_lit", fi.pc_d_o, 32'h8);
    cycle("run3", 1, 0, 0, 0);
    chk("run3.pc_f_lit", fi.pc_f_o, 32'h10);

    // Redirect to an unaligned target; low bits are dropped.
    cycle("redir", 1, 0, 1, 32'h0000_0102);
    chk("redir.pc_f_lit", fi.pc_f_o, 32'h100);
    chk("redir.vld_lit", 32'(fi.valid_d_o), 32'h0);
    cycle("redir_tgt", 1, 0, 0, 0);
    chk("redir_tgt.pc_d_lit", fi.pc_d_o, 32'h100);

    // Redirect wins over a simultaneous stall.
    cycle("redir_stall", 1, 1, 1, 32'h0000_0040);
    chk("redir_stall.pc_f_lit", fi.pc_f_o, 32'h40);
    chk("redir_stall.instr_lit", fi.instr_d_o, 32'h0000_0013);

    // Near the ROM end: 0xFF8, 0xFFC are in range, 0x1000 is not.
    cycle("edge", 1, 0, 1, 32'h0000_0FF8);
    cycle("edge", 1, 0, 0, 0);
    cycle("edge", 1, 0, 0, 0);

    // Randomized stall/redirect/reset traffic.
    for (int i = 0; i < 400; i++) begin
      bit rn, st, rd;
      logic [31:0] tgt;
      rn  = ($urandom_range(99) >= 2);
      st  = ($urandom_range(99) < 30);
      rd  = ($urandom_range(99) < 15);
      tgt = ($urandom_range(3) == 0) ? $urandom() : {20'h0, 12'($urandom())};
      cycle("rnd", rn, st, rd, tgt);
    end

    // Reset for one edge while stalled with a redirect pending.
    cycle("pre", 1, 0, 0, 0);
    cycle("pre", 1, 0, 0, 0);
    cycle("rst_mid", 0, 1, 1, 32'h0000_0200);
    chk("rst_mid.pc_f_lit", fi.pc_f_o, 32'h0);
    chk("rst_mid.vld_lit", 32'(fi.valid_d_o), 32'h0);
    chk("rst_mid.instr_lit", fi.instr_d_o, 32'h0000_0013);
    cycle("post", 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
